playhead_seq: RTL
=================

// Module: playhead_seq
// PURPOSE
//   Parametrised playhead timing engine for the DAW timeline view; successor to the single-measure playhead.
//   Moves playhead_x across a programmable region at exact BPM rate using a phase accumulator instead of a divider.
//   Supports play/pause/stop, loop or one-shot, and emits pixel, beat and wrap strobes for metronome/sequencer logic.
//   Sits between the transport controls and the VGA timeline renderer and note scheduler.
// PARAMETERS
//   CLK_HZ     50_000_000  system clock frequency; DEN = 60*CLK_HZ is the accumulator modulus
//   XW         10          width of all x/width/spacing fields
//   BPM_W      8           width of bpm input
//   MIN_BPM    20          bpm values below this are clamped up to it
//   ACC_W      40          accumulator width; must hold DEN + max(bpm*spacing)
//   BEAT_IDX_W 8           width of beat_idx counter
// PORTS
//   clk          in   1          system clock, all logic on posedge
//   rst          in   1          synchronous active-low reset
//   play_req     in   1          1-cycle pulse: start or resume
//   pause_req    in   1          1-cycle pulse: freeze position
//   stop_req     in   1          1-cycle pulse: return to region start, idle
//   loop_en      in   1          1 = wrap at region end, 0 = stop at region end
//   bpm          in   BPM_W      tempo, sampled every cycle
//   region_x     in   XW         first pixel of play region
//   region_w     in   XW         region width in pixels (0 treated as 1)
//   beat_spacing in   XW         pixels per beat (0 treated as 1)
//   playhead_x   out  XW         current playhead pixel
//   state        out  2          0=IDLE 1=PLAYING 2=PAUSED
//   pixel_tick   out  1          1-cycle pulse when playhead_x advances/wraps
//   beat_tick    out  1          1-cycle pulse at each beat boundary
//   wrap_tick    out  1          1-cycle pulse when loop wraps to region_x
//   done         out  1          1-cycle pulse when one-shot reaches region end
//   beat_idx     out  BEAT_IDX_W beats since region start, wraps modulo 2^BEAT_IDX_W
// BEHAVIOUR
//   Reset (rst=0 at posedge): state=IDLE, playhead_x=region_x, acc=0, pix_in_beat=0, beat_idx=0, all strobes 0.
//   All outputs registered. Request priority in same cycle: stop > pause > play.
//   IDLE: playhead_x tracks region_x, acc=0. play_req -> PLAYING next cycle, beat_tick=1 that cycle (beat 0).
//   PLAYING: each cycle acc += INC, INC = max(bpm,MIN_BPM)*spacing (zero-extended to ACC_W).
//     If acc+INC >= DEN: acc <= acc+INC-DEN, advance one pixel, pixel_tick=1. At most one pixel per cycle;
//     if INC >= DEN, advance every cycle and acc<=0 (saturated).
//     Advance: if playhead_x < region_x+region_w-1 (XW+1-bit sum) -> +1; else end-of-region:
//       loop_en=1 -> playhead_x=region_x, wrap_tick=1, beat_tick=1, pix_in_beat=0, beat_idx=0;
//       loop_en=0 -> playhead_x=region_x, state=IDLE, done=1, no pixel_tick.
//     Non-end advance: pix_in_beat+1; on reaching spacing -> pix_in_beat=0, beat_tick=1, beat_idx+1.
//     pause_req -> PAUSED next cycle, no advance that cycle. stop_req -> IDLE, playhead_x=region_x, counters cleared.
//   PAUSED: playhead_x, acc, pix_in_beat, beat_idx frozen. play_req resumes (no beat_tick); stop_req -> IDLE.
//   play_req while PLAYING and pause_req while IDLE/PAUSED are ignored.
//   Region change mid-play: if playhead_x outside [region_x, region_x+region_w-1], next cycle jump to region_x,
//     acc and counters cleared, wrap_tick=1. bpm/spacing changes take effect next cycle, acc kept (no glitch).
//   pix_in_beat >= new spacing -> treated as boundary on next advance.
// TESTING (CLK_HZ=100 -> DEN=6000)
//   bpm=120 spacing=10 region 100/40, play -> pixel_tick every 5 cycles, beat_tick every 50, beat_idx 0,1,2,3.
//   loop_en=1 reaching x=139 -> next advance x=100, wrap_tick=beat_tick=1, beat_idx=0; loop_en=0 -> done=1, IDLE, x=100.
//   bpm=5 -> clamped to 20: INC=200, pixel every 30 cycles; bpm=255 spacing=60 (INC>=DEN) -> pixel every cycle.
//   pause at x=117 for 200 cycles -> x/beat_idx frozen; play -> resumes with first pixel after remaining acc delta.
//   play+pause+stop same cycle -> IDLE; rst=0 mid-play -> all outputs reset values next edge, x=region_x.
//   region_x changed 100->200 while x=130 -> next cycle x=200, wrap_tick=1, counters cleared.

Source files
------------

// File: rtl/playhead_seq.sv
// playhead_seq: BPM-accurate playhead timing engine for the DAW timeline view.
// A phase accumulator (modulus 60*CLK_HZ) advances playhead_x by at most one
// pixel per cycle across a programmable region. It handles play/pause/stop and
// loop/one-shot, and emits pixel, beat, wrap and done strobes.
module playhead_seq #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned XW         = 10,
  parameter int unsigned BPM_W      = 8,
  parameter int unsigned MIN_BPM    = 20,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned BEAT_IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_req,
  input  logic                  pause_req,
  input  logic                  stop_req,
  input  logic                  loop_en,
  input  logic [BPM_W-1:0]      bpm,
  input  logic [XW-1:0]         region_x,
  input  logic [XW-1:0]         region_w,
  input  logic [XW-1:0]         beat_spacing,
  output logic [XW-1:0]         playhead_x,
  output logic [1:0]            state,
  output logic                  pixel_tick,
  output logic                  beat_tick,
  output logic                  wrap_tick,
  output logic                  done,
  output logic [BEAT_IDX_W-1:0] beat_idx
);

  // Accumulator modulus: one pixel per (60*CLK_HZ) units of bpm*spacing.
  localparam logic [ACC_W-1:0] DEN = ACC_W'(64'(CLK_HZ) * 64'd60);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [XW-1:0]         pib_q, pib_d;
  logic [BEAT_IDX_W-1:0] beat_idx_q, beat_idx_d;
  logic                  pixel_tick_q, pixel_tick_d;
  logic                  beat_tick_q, beat_tick_d;
  logic                  wrap_tick_q, wrap_tick_d;
  logic                  done_q, done_d;

  logic [BPM_W-1:0] bpm_eff;
  logic [XW-1:0]    spacing_eff;
  logic [XW-1:0]    width_eff;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] sum;
  logic             saturated;
  logic             step;
  logic [XW:0]      region_end;
  logic             out_of_region;
  logic             at_end;
  logic [XW:0]      pib_next;
  logic             beat_hit;
  logic             play_go;

  // Derived tempo/geometry terms shared by every state.
  always_comb begin
    bpm_eff       = (bpm < BPM_W'(MIN_BPM)) ? BPM_W'(MIN_BPM) : bpm;
    spacing_eff   = (beat_spacing == '0) ? XW'(1) : beat_spacing;
    width_eff     = (region_w == '0) ? XW'(1) : region_w;
    inc           = ACC_W'(bpm_eff) * ACC_W'(spacing_eff);
    sum           = acc_q + inc;
    saturated     = (inc >= DEN);
    step          = saturated || (sum >= DEN);
    region_end    = {1'b0, region_x} + {1'b0, width_eff} - (XW+1)'(1);
    out_of_region = ({1'b0, x_q} < {1'b0, region_x}) || ({1'b0, x_q} > region_end);
    at_end        = ({1'b0, x_q} >= region_end);
    pib_next      = {1'b0, pib_q} + (XW+1)'(1);
    beat_hit      = (pib_next >= {1'b0, spacing_eff});
    play_go       = play_req && !pause_req && !stop_req;
  end

  // Next-state, position, accumulator and strobe computation.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    acc_d        = acc_q;
    pib_d        = pib_q;
    beat_idx_d   = beat_idx_q;
    pixel_tick_d = 1'b0;
    beat_tick_d  = 1'b0;
    wrap_tick_d  = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        x_d        = region_x;
        acc_d      = '0;
        pib_d      = '0;
        beat_idx_d = '0;
        if (play_go) begin
          state_d     = PLAYING;
          beat_tick_d = 1'b1;
        end
      end

      PLAYING: begin
        if (stop_req) begin
          state_d    = IDLE;
          x_d        = region_x;
          acc_d      = '0;
          pib_d      = '0;
          beat_idx_d = '0;
        end else if (pause_req) begin
          state_d = PAUSED;
        end else if (out_of_region) begin
          x_d         = region_x;
          acc_d       = '0;
          pib_d       = '0;
          beat_idx_d  = '0;
          wrap_tick_d = 1'b1;
        end else if (step) begin
          acc_d = saturated ? '0 : (sum - DEN);
          if (!at_end) begin
            x_d          = x_q + XW'(1);
            pixel_tick_d = 1'b1;
            if (beat_hit) begin
              pib_d       = '0;
              beat_tick_d = 1'b1;
              beat_idx_d  = beat_idx_q + BEAT_IDX_W'(1);
            end else begin
              pib_d = pib_next[XW-1:0];
            end
          end else if (loop_en) begin
            x_d          = region_x;
            pixel_tick_d = 1'b1;
            wrap_tick_d  = 1'b1;
            beat_tick_d  = 1'b1;
            pib_d        = '0;
            beat_idx_d   = '0;
          end else begin
            state_d    = IDLE;
            x_d        = region_x;
            acc_d      = '0;
            pib_d      = '0;
            beat_idx_d = '0;
            done_d     = 1'b1;
          end
        end else begin
          acc_d = sum;
        end
      end

      PAUSED: begin
        if (stop_req) begin
          state_d    = IDLE;
          x_d        = region_x;
          acc_d      = '0;
          pib_d      = '0;
          beat_idx_d = '0;
        end else if (play_go) begin
          state_d = PLAYING;
        end
      end

      default: begin
        state_d    = IDLE;
        x_d        = region_x;
        acc_d      = '0;
        pib_d      = '0;
        beat_idx_d = '0;
      end
    endcase
  end

  // Register all state and outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      x_q          <= region_x;
      acc_q        <= '0;
      pib_q        <= '0;
      beat_idx_q   <= '0;
      pixel_tick_q <= 1'b0;
      beat_tick_q  <= 1'b0;
      wrap_tick_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      acc_q        <= acc_d;
      pib_q        <= pib_d;
      beat_idx_q   <= beat_idx_d;
      pixel_tick_q <= pixel_tick_d;
      beat_tick_q  <= beat_tick_d;
      wrap_tick_q  <= wrap_tick_d;
      done_q       <= done_d;
    end
  end

  assign playhead_x = x_q;
  assign state      = state_q;
  assign pixel_tick = pixel_tick_q;
  assign beat_tick  = beat_tick_q;
  assign wrap_tick  = wrap_tick_q;
  assign done       = done_q;
  assign beat_idx   = beat_idx_q;

endmodule
